// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide front-end.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RUN,
    DONE
  } div_state_e;

  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
    logic div_zero;
    logic ovf;
  } div_flags_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !((op == DIV_OP_DIVU) || (op == DIV_OP_REMU));
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_rv32m_ctrl_if.sv
// Request/response handshake plus unsigned divider core bus for div_rv32m_ctrl.
interface div_rv32m_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_start;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic        core_busy;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, rsp_ready, core_q, core_r, core_busy,
    input  req_ready, rsp_valid, rsp_data, core_a, core_b, core_start
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, rsp_ready, core_q, core_r, core_busy,
    output req_ready, rsp_valid, rsp_data, core_a, core_b, core_start
  );
endinterface

// File: rtl/div_sign_fix.sv
// Combinational sign handling: operand magnitudes and special-case flags for a
// request, and final quotient/remainder selection from latched flags.
module div_sign_fix
  import div_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output div_flags_t  flags,
  input  div_flags_t  res_flags,
  input  logic [31:0] res_mag_a,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic [31:0] result
);

  logic        signed_op;
  logic [31:0] rs1_raw;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    signed_op      = op_is_signed(op);
    mag_a          = (signed_op && rs1[31]) ? (32'd0 - rs1) : rs1;
    mag_b          = (signed_op && rs2[31]) ? (32'd0 - rs2) : rs2;
    flags          = '0;
    flags.is_rem   = op_is_rem(op);
    flags.neg_q    = signed_op && (rs1[31] != rs2[31]) && (rs2 != 32'd0);
    flags.neg_r    = signed_op && rs1[31];
    flags.div_zero = (rs2 == 32'd0);
    flags.ovf      = signed_op && (rs1 == DIV_OVF_DIVIDEND) && (rs2 == DIV_ALL_ONES);
  end

  // The original dividend is rebuilt from its magnitude, so it need not be stored.
  always_comb begin
    rs1_raw = res_flags.neg_r ? (32'd0 - res_mag_a) : res_mag_a;
    q_fix   = res_flags.neg_q ? (32'd0 - core_q) : core_q;
    r_fix   = res_flags.neg_r ? (32'd0 - core_r) : core_r;
    if (res_flags.div_zero) begin
      result = res_flags.is_rem ? rs1_raw : DIV_ALL_ONES;
    end else if (res_flags.ovf) begin
      result = res_flags.is_rem ? 32'd0 : DIV_OVF_DIVIDEND;
    end else begin
      result = res_flags.is_rem ? r_fix : q_fix;
    end
  end

endmodule

// File: rtl/div_rv32m_ctrl.sv
// RV32M DIV/DIVU/REM/REMU front-end driving an unsigned divider core.
// Define DIV_EARLY_OUT_EN to let zero-divisor and signed-overflow requests bypass the core.
module div_rv32m_ctrl
  import div_pkg::*;
(
  input logic             clk,
  input logic             rst,
  div_rv32m_ctrl_if.slave bus
);

  div_state_e  state_q, state_d;
  div_flags_t  flags_q, flags_d;
  div_flags_t  req_flags, res_flags;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic [31:0] req_mag_a, req_mag_b, res_mag_a;
  logic [31:0] result;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        core_start_q, core_start_d;
  logic        accept;

  div_sign_fix u_sign_fix (
    .op        (bus.req_op),
    .rs1       (bus.req_rs1),
    .rs2       (bus.req_rs2),
    .mag_a     (req_mag_a),
    .mag_b     (req_mag_b),
    .flags     (req_flags),
    .res_flags (res_flags),
    .res_mag_a (res_mag_a),
    .core_q    (bus.core_q),
    .core_r    (bus.core_r),
    .result    (result)
  );

`ifdef DIV_EARLY_OUT_EN
  always_comb begin
    res_flags = (state_q == IDLE) ? req_flags : flags_q;
    res_mag_a = (state_q == IDLE) ? req_mag_a : mag_a_q;
  end
`else
  always_comb begin
    res_flags = flags_q;
    res_mag_a = mag_a_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    rsp_data_d = rsp_data_q;
    accept     = bus.req_valid && req_ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          flags_d = req_flags;
          mag_a_d = req_mag_a;
          mag_b_d = req_mag_b;
          state_d = START;
`ifdef DIV_EARLY_OUT_EN
          if (req_flags.div_zero || req_flags.ovf) begin
            rsp_data_d = result;
            state_d    = DONE;
          end
`endif
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.core_busy) state_d = RUN;
      end
      RUN: begin
        if (!bus.core_busy) begin
          rsp_data_d = result;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so none depends combinationally on inputs.
    req_ready_d  = (state_d == IDLE);
    core_start_d = (state_d == START);
    rsp_valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flags_q      <= '0;
      mag_a_q      <= 32'd0;
      mag_b_q      <= 32'd0;
      rsp_data_q   <= 32'd0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      mag_a_q      <= mag_a_d;
      mag_b_q      <= mag_b_d;
      rsp_data_q   <= rsp_data_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      core_start_q <= core_start_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.core_a     = mag_a_q;
  assign bus.core_b     = mag_b_q;
  assign bus.core_start = core_start_q;

endmodule

// File: tb/tb_div_rv32m_ctrl.sv
// Randomized and directed bench for div_rv32m_ctrl with a behavioural divider core
// and a reference model built from signed/unsigned integer arithmetic.
module tb_div_rv32m_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   coreStarts = 0;
  int   coreCnt = 0;

  always #5 clk = ~clk;

  div_rv32m_ctrl_if bus();

  div_rv32m_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural unsigned core: busy for 33 cycles after start; garbage on divide by zero.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_busy <= 1'b0;
      bus.core_q    <= 32'd0;
      bus.core_r    <= 32'd0;
      coreCnt       <= 0;
    end else if (bus.core_start) begin
      bus.core_busy <= 1'b1;
      coreCnt       <= 32;
      coreStarts    <= coreStarts + 1;
    end else if (bus.core_busy) begin
      if (coreCnt == 0) begin
        bus.core_busy <= 1'b0;
        if (bus.core_b == 32'd0) begin
          bus.core_q <= $urandom;
          bus.core_r <= $urandom;
        end else begin
          bus.core_q <= bus.core_a / bus.core_b;
          bus.core_r <= bus.core_a % bus.core_b;
        end
      end else begin
        coreCnt <= coreCnt - 1;
      end
    end
  end

  function automatic logic isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    return (b == 32'd0) || (sgn && a == DIV_OVF_DIVIDEND && b == DIV_ALL_ONES);
  endfunction

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic sgn;
    logic rem;
    sa  = a;
    sb  = b;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    rem = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic int expLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (isSpecial(op, a, b)) return 1;
`else
    if (isSpecial(op, a, b)) return 36;
`endif
    return 36;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold);
    int          n;
    int          lat;
    int          startsBefore;
    int          expStarts;
    logic [31:0] exp;
    logic [31:0] held;
    exp       = refResult(op, a, b);
    expStarts = (expLatency(op, a, b) == 1) ? 0 : 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    startsBefore = coreStarts;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    @(negedge clk);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLatency(op, a, b)));
    checkOutput("rsp_data", bus.rsp_data, exp);
    held = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_data", bus.rsp_data, held);
      checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    checkOutput("core_starts", 32'(coreStarts - startsBefore), 32'(expStarts));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd3};
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_rs1   = 32'd0;
    bus.req_rs2   = 32'd0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", bus.rsp_data, 32'd0);
    checkOutput("rst_core_a", bus.core_a, 32'd0);
    checkOutput("rst_core_b", bus.core_b, 32'd0);
    checkOutput("rst_core_start", 32'(bus.core_start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    applyStimulus(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 0);
    applyStimulus(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10, 0);
    applyStimulus(DIV_OP_DIV,  32'd5, 32'd0, 0);
    applyStimulus(DIV_OP_REM,  32'd5, 32'd0, 0);
    applyStimulus(DIV_OP_REMU, 32'hFFFF_FFFB, 32'd0, 0);
    applyStimulus(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(DIV_OP_DIV,  32'd1000, 32'hFFFF_FFF9, 10);

    for (int t = 0; t < 20; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      applyStimulus(op, a, b, $urandom_range(0, 3));
    end

    // Reset while the core is running, then confirm a clean restart.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = DIV_OP_DIV;
    bus.req_rs1   = 32'hFFFF_FC18;
    bus.req_rs2   = 32'd9;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("run_core_a", bus.core_a, 32'd1000);
    checkOutput("run_core_b", bus.core_b, 32'd9);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_core_start", 32'(bus.core_start), 32'd0);
    checkOutput("midrst_core_a", bus.core_a, 32'd0);
    checkOutput("midrst_core_b", bus.core_b, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(DIV_OP_DIV, 32'd100, 32'd7, 0);
    checkOutput("restart_result", bus.rsp_data, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
